// File: rtl/cdma_lite_regs_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cdma_lite_regs_if                                           |
// | Brief  : AXI4-Lite bus bundle between the DMA config master and the  |
// |          CDMA-compatible register block.                             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface cdma_lite_regs_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/cdma_lite_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cdma_lite_regs                                              |
// | Brief  : AXI4-Lite responder with CDMA-style CR/SR/SA/DA/BTT regs;   |
// |          a BTT write launches the local copy engine.                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module cdma_lite_regs #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BTT_W  = 26
) (
  input  wire                 clk,
  input  wire                 rst_n,
  cdma_lite_regs_if.slave     s_axi,
  output logic                xfer_start,
  output logic [DATA_W-1:0]   xfer_src,
  output logic [DATA_W-1:0]   xfer_dst,
  output logic [BTT_W-1:0]    xfer_len,
  input  wire                 xfer_done,
  input  wire                 xfer_err,
  output logic                irq
);

  localparam logic [1:0]        c_OKAY    = 2'b00;
  localparam logic [1:0]        c_SLVERR  = 2'b10;
  localparam logic [2:0]        c_SEL_CR  = 3'd0;
  localparam logic [2:0]        c_SEL_SR  = 3'd1;
  localparam logic [2:0]        c_SEL_SA  = 3'd2;
  localparam logic [2:0]        c_SEL_DA  = 3'd3;
  localparam logic [2:0]        c_SEL_BTT = 3'd4;
  localparam logic [2:0]        c_SEL_NONE = 3'd7;
  localparam logic [ADDR_W-3:0] c_IDX_CR  = (ADDR_W-2)'(8'h00);
  localparam logic [ADDR_W-3:0] c_IDX_SR  = (ADDR_W-2)'(8'h01);
  localparam logic [ADDR_W-3:0] c_IDX_SA  = (ADDR_W-2)'(8'h06);
  localparam logic [ADDR_W-3:0] c_IDX_DA  = (ADDR_W-2)'(8'h08);
  localparam logic [ADDR_W-3:0] c_IDX_BTT = (ADDR_W-2)'(8'h0A);

  typedef enum logic [0:0] {WIDLE = 1'b0, WRESP = 1'b1} wstate_e;
  typedef enum logic [0:0] {RIDLE = 1'b0, RDATA = 1'b1} rstate_e;

  wstate_e             r_wstate, w_wstate_nxt;
  rstate_e             r_rstate, w_rstate_nxt;
  logic                w_wr_en, w_rd_en;
  logic [1:0]          w_wr_resp, w_rd_resp;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_cr_wr, w_sr_wr, w_sa_wr, w_da_wr, w_btt_wr;
  logic                w_launch, w_soft_rst, w_fin;
  logic [DATA_W-1:0]   r_sa, r_da, r_rdata;
  logic [BTT_W-1:0]    r_btt;
  logic                r_irq_en, r_done, r_err, r_busy, r_irq, r_xfer_start;
  logic [1:0]          r_bresp, r_rresp;
  logic                w_unused_addr_bits;

  // Byte-address low bits carry no meaning for word registers.
  assign w_unused_addr_bits = &{1'b0, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  function automatic logic [2:0] f_decode(input logic [ADDR_W-3:0] idx);
    case (idx)
      c_IDX_CR:  return c_SEL_CR;
      c_IDX_SR:  return c_SEL_SR;
      c_IDX_SA:  return c_SEL_SA;
      c_IDX_DA:  return c_SEL_DA;
      c_IDX_BTT: return c_SEL_BTT;
      default:   return c_SEL_NONE;
    endcase
  endfunction

  // Write channel state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wstate <= WIDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  // Write FSM: AW and W are only ever taken together, one response at a time.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_en      = 1'b0;
    case (r_wstate)
      WIDLE: if (s_axi.awvalid && s_axi.wvalid) begin
        w_wr_en      = 1'b1;
        w_wstate_nxt = WRESP;
      end
      WRESP: if (s_axi.bready) w_wstate_nxt = WIDLE;
      default: w_wstate_nxt = WIDLE;
    endcase
  end

  assign s_axi.awready = w_wr_en;
  assign s_axi.wready  = w_wr_en;
  assign s_axi.bvalid  = (r_wstate == WRESP);
  assign s_axi.bresp   = r_bresp;

  // Write decode: which register is hit, the response, and launch/soft-reset qualifiers.
  always_comb begin
    w_wr_resp  = c_OKAY;
    w_cr_wr    = 1'b0;
    w_sr_wr    = 1'b0;
    w_sa_wr    = 1'b0;
    w_da_wr    = 1'b0;
    w_btt_wr   = 1'b0;
    w_launch   = 1'b0;
    w_soft_rst = 1'b0;
    if (w_wr_en) begin
      case (f_decode(s_axi.awaddr[ADDR_W-1:2]))
        c_SEL_CR: begin
          w_cr_wr    = 1'b1;
          w_soft_rst = s_axi.wdata[2] & ~r_busy;
        end
        c_SEL_SR: w_sr_wr = 1'b1;
        c_SEL_SA: w_sa_wr = 1'b1;
        c_SEL_DA: w_da_wr = 1'b1;
        c_SEL_BTT: begin
          if (r_busy) begin
            w_wr_resp = c_SLVERR;
          end else begin
            w_btt_wr = 1'b1;
            w_launch = |s_axi.wdata[BTT_W-1:0];
          end
        end
        default: w_wr_resp = c_SLVERR;
      endcase
    end
  end

  // Engine completion only counts while a transfer is outstanding.
  assign w_fin = r_busy & (xfer_done | xfer_err);

  // Configuration registers and write response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_da     <= '0;
      r_btt    <= '0;
      r_irq_en <= 1'b0;
      r_bresp  <= c_OKAY;
    end else begin
      if (w_wr_en) r_bresp <= w_wr_resp;
      if (w_soft_rst) begin
        r_sa     <= '0;
        r_da     <= '0;
        r_btt    <= '0;
        r_irq_en <= 1'b0;
      end else begin
        if (w_cr_wr)  r_irq_en <= s_axi.wdata[0];
        if (w_sa_wr)  r_sa     <= s_axi.wdata;
        if (w_da_wr)  r_da     <= s_axi.wdata;
        if (w_btt_wr) r_btt    <= s_axi.wdata[BTT_W-1:0];
      end
    end
  end

  // Busy/flag tracking, launch pulse and registered interrupt; a flag set wins over W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_irq        <= 1'b0;
      r_xfer_start <= 1'b0;
    end else begin
      r_xfer_start <= w_launch;
      r_busy       <= w_launch | (r_busy & ~w_fin);
      r_irq        <= r_irq_en & (r_done | r_err);
      if (w_soft_rst) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        r_done <= (r_done & ~(w_sr_wr & s_axi.wdata[12])) | (w_fin & xfer_done);
        r_err  <= (r_err  & ~(w_sr_wr & s_axi.wdata[14])) | (w_fin & xfer_err);
      end
    end
  end

  // Read channel state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rstate <= RIDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  // Read FSM: accept an address whenever idle, hold data until the master takes it.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rd_en      = 1'b0;
    case (r_rstate)
      RIDLE: if (s_axi.arvalid) begin
        w_rd_en      = 1'b1;
        w_rstate_nxt = RDATA;
      end
      RDATA: if (s_axi.rready) w_rstate_nxt = RIDLE;
      default: w_rstate_nxt = RIDLE;
    endcase
  end

  // Read data mux built from pre-edge register state.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = c_OKAY;
    case (f_decode(s_axi.araddr[ADDR_W-1:2]))
      c_SEL_CR:  w_rd_data[0] = r_irq_en;
      c_SEL_SR: begin
        w_rd_data[1]  = ~r_busy;
        w_rd_data[12] = r_done;
        w_rd_data[14] = r_err;
      end
      c_SEL_SA:  w_rd_data = r_sa;
      c_SEL_DA:  w_rd_data = r_da;
      c_SEL_BTT: w_rd_data[BTT_W-1:0] = r_btt;
      default:   w_rd_resp = c_SLVERR;
    endcase
  end

  // Capture read data and response on the address handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_rresp <= c_OKAY;
    end else if (w_rd_en) begin
      r_rdata <= w_rd_data;
      r_rresp <= w_rd_resp;
    end
  end

  assign s_axi.arready = (r_rstate == RIDLE);
  assign s_axi.rvalid  = (r_rstate == RDATA);
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  assign xfer_start = r_xfer_start;
  assign xfer_src   = r_sa;
  assign xfer_dst   = r_da;
  assign xfer_len   = r_btt;
  assign irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_cdma_lite_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_cdma_lite_regs                                           |
// | Brief  : Directed self-checking bench for cdma_lite_regs with a      |
// |          transaction-rule reference model.                           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_cdma_lite_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        xfer_start, irq, xfer_done, xfer_err;
  logic [31:0] xfer_src, xfer_dst;
  logic [25:0] xfer_len;
  int          n_cmp = 0;
  int          n_fail = 0;

  cdma_lite_regs_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  cdma_lite_regs #(.ADDR_W(10), .DATA_W(32), .BTT_W(26)) dut (
    .clk(clk), .rst_n(rst_n), .s_axi(bus),
    .xfer_start(xfer_start), .xfer_src(xfer_src), .xfer_dst(xfer_dst),
    .xfer_len(xfer_len), .xfer_done(xfer_done), .xfer_err(xfer_err), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (register-map rules, transaction level)
  logic [31:0] m_sa, m_da, m_rdata;
  logic [25:0] m_btt;
  logic        m_irq_en, m_done, m_err, m_busy, m_irq, m_start;
  logic        m_wpend, m_rpend, was_busy, n_start, n_irq;
  logic [1:0]  m_bresp, m_rresp;

  task automatic m_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] r);
    d = 32'h0; r = 2'b00;
    case (a[9:2])
      8'h00: d = {31'h0, m_irq_en};
      8'h01: d = (32'(m_err) << 14) | (32'(m_done) << 12) | (32'(!m_busy) << 1);
      8'h06: d = m_sa;
      8'h08: d = m_da;
      8'h0A: d = {6'h0, m_btt};
      default: r = 2'b10;
    endcase
  endtask

  task automatic m_write(input logic [9:0] a, input logic [31:0] d,
                         output logic [1:0] r, output logic st);
    r = 2'b00; st = 1'b0;
    case (a[9:2])
      8'h00: if (d[2] && !m_busy) begin
               m_sa = 0; m_da = 0; m_btt = 0; m_irq_en = 0; m_done = 0; m_err = 0;
             end else m_irq_en = d[0];
      8'h01: begin
               if (d[12]) m_done = 1'b0;
               if (d[14]) m_err = 1'b0;
             end
      8'h06: m_sa = d;
      8'h08: m_da = d;
      8'h0A: if (m_busy) r = 2'b10;
             else begin
               m_btt = d[25:0];
               if (d[25:0] != 0) begin st = 1'b1; m_busy = 1'b1; end
             end
      default: r = 2'b10;
    endcase
  endtask

  // Model advances once per clock from the inputs the master presented.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sa = 0; m_da = 0; m_btt = 0; m_irq_en = 0; m_done = 0; m_err = 0;
      m_busy = 0; m_irq = 0; m_start = 0; m_wpend = 0; m_rpend = 0;
      m_bresp = 0; m_rresp = 0; m_rdata = 0;
    end else begin
      n_irq = m_irq_en & (m_done | m_err);
      was_busy = m_busy;
      n_start = 1'b0;
      if (m_rpend) begin
        if (bus.rready) m_rpend = 1'b0;
      end else if (bus.arvalid) begin
        m_rpend = 1'b1;
        m_read(bus.araddr, m_rdata, m_rresp);
      end
      if (m_wpend) begin
        if (bus.bready) m_wpend = 1'b0;
      end else if (bus.awvalid && bus.wvalid) begin
        m_wpend = 1'b1;
        m_write(bus.awaddr, bus.wdata, m_bresp, n_start);
      end
      if (was_busy && (xfer_done || xfer_err)) begin
        m_busy = 1'b0;
        if (xfer_done) m_done = 1'b1;
        if (xfer_err)  m_err = 1'b1;
      end
      m_start = n_start;
      m_irq = n_irq;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_awready", bus.awready, !m_wpend && bus.awvalid && bus.wvalid);
      chk("cyc_wready", bus.wready, !m_wpend && bus.awvalid && bus.wvalid);
      chk("cyc_bvalid", bus.bvalid, m_wpend);
      if (m_wpend) chk("cyc_bresp", bus.bresp, m_bresp);
      chk("cyc_arready", bus.arready, !m_rpend);
      chk("cyc_rvalid", bus.rvalid, m_rpend);
      if (m_rpend) begin
        chk("cyc_rdata", bus.rdata, m_rdata);
        chk("cyc_rresp", bus.rresp, m_rresp);
      end
      chk("cyc_xfer_start", xfer_start, m_start);
      chk("cyc_xfer_src", xfer_src, m_sa);
      chk("cyc_xfer_dst", xfer_dst, m_da);
      chk("cyc_xfer_len", xfer_len, m_btt);
      chk("cyc_irq", irq, m_irq);
    end
  end

  // ---------------- directed stimulus
  task automatic do_write(input logic [9:0] a, input logic [31:0] d,
                          input logic [1:0] er, input logic es);
    @(posedge clk); #1;
    bus.awaddr = a; bus.wdata = d; bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.awready) break;
    end
    chk("w_accept", bus.awready, 1);
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    @(negedge clk);
    chk("w_bvalid", bus.bvalid, 1);
    chk("w_bresp", bus.bresp, er);
    chk("w_xfer_start", xfer_start, es);
  endtask

  task automatic do_read(input logic [9:0] a, input logic [31:0] ed, input logic [1:0] er);
    @(posedge clk); #1;
    bus.araddr = a; bus.arvalid = 1; bus.rready = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.arready) break;
    end
    chk("r_accept", bus.arready, 1);
    @(posedge clk); #1;
    bus.arvalid = 0;
    @(negedge clk);
    chk("r_rvalid", bus.rvalid, 1);
    chk("r_rdata", bus.rdata, ed);
    chk("r_rresp", bus.rresp, er);
  endtask

  task automatic pulse(input logic d, input logic e);
    @(posedge clk); #1;
    xfer_done = d; xfer_err = e;
    @(posedge clk); #1;
    xfer_done = 0; xfer_err = 0;
  endtask

  initial begin
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wvalid = 0; bus.bready = 1;
    bus.araddr = 0; bus.arvalid = 0; bus.rready = 1;
    xfer_done = 0; xfer_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // 1: reset state
    chk("rst_irq", irq, 0);
    do_read(10'h004, 32'h0000_0002, 2'b00);

    // 2: program and launch
    do_write(10'h018, 32'h0002_0000, 2'b00, 0);
    do_write(10'h020, 32'h0000_0000, 2'b00, 0);
    do_write(10'h028, 32'd20, 2'b00, 1);
    chk("src", xfer_src, 32'h0002_0000);
    chk("dst", xfer_dst, 32'h0);
    chk("len", xfer_len, 32'd20);
    do_read(10'h004, 32'h0000_0000, 2'b00);

    // 3: completion, interrupt, W1C and set-beats-clear
    do_write(10'h000, 32'h1, 2'b00, 0);
    pulse(1, 0);
    @(posedge clk); #1;
    chk("irq_set", irq, 1);
    do_read(10'h004, 32'h0000_1002, 2'b00);
    do_write(10'h004, 32'h0000_1000, 2'b00, 0);
    @(posedge clk); #1;
    chk("irq_clr", irq, 0);
    do_write(10'h028, 32'd5, 2'b00, 1);
    @(posedge clk); #1;
    bus.awaddr = 10'h004; bus.wdata = 32'h1000; bus.awvalid = 1; bus.wvalid = 1;
    xfer_done = 1;
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0; xfer_done = 0;
    do_read(10'h004, 32'h0000_1002, 2'b00);

    // 4: BTT while busy, unmapped accesses, error completion
    do_write(10'h028, 32'd8, 2'b00, 1);
    do_write(10'h028, 32'd9, 2'b10, 0);
    chk("len_kept", xfer_len, 32'd8);
    do_write(10'h3FC, 32'hDEAD, 2'b10, 0);
    do_read(10'h3FC, 32'h0, 2'b10);
    pulse(0, 1);
    do_read(10'h004, 32'h0000_5002, 2'b00);
    do_write(10'h004, 32'h0000_5000, 2'b00, 0);
    do_read(10'h004, 32'h0000_0002, 2'b00);

    // soft reset while idle clears everything, while busy is ignored
    do_write(10'h000, 32'h4, 2'b00, 0);
    chk("srst_src", xfer_src, 32'h0);
    chk("srst_len", xfer_len, 32'h0);
    do_read(10'h000, 32'h0, 2'b00);
    do_write(10'h018, 32'h1234, 2'b00, 0);
    do_write(10'h028, 32'd3, 2'b00, 1);
    do_write(10'h000, 32'h5, 2'b00, 0);
    chk("srst_busy_src", xfer_src, 32'h1234);
    pulse(1, 0);
    do_read(10'h004, 32'h0000_1002, 2'b00);
    do_write(10'h004, 32'h1000, 2'b00, 0);
    do_write(10'h000, 32'h0, 2'b00, 0);

    // 5: AW without W, then a stalled B channel blocking the next write
    @(posedge clk); #1;
    bus.awaddr = 10'h018; bus.awvalid = 1; bus.wvalid = 0;
    repeat (4) begin
      @(negedge clk);
      chk("aw_only_ready", bus.awready, 0);
    end
    @(posedge clk); #1;
    bus.awvalid = 0;
    @(posedge clk); #1;
    bus.awaddr = 10'h020; bus.wdata = 32'hA5; bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
    @(negedge clk);
    chk("stall_first_acc", bus.awready, 1);
    @(posedge clk); #1;
    bus.awaddr = 10'h018; bus.wdata = 32'h77;
    repeat (3) begin
      @(negedge clk);
      chk("stall_bvalid", bus.bvalid, 1);
      chk("stall_awready", bus.awready, 0);
    end
    @(posedge clk); #1;
    bus.bready = 1;
    @(negedge clk);
    chk("stall_still_blocked", bus.awready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_second_acc", bus.awready, 1);
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    @(negedge clk);
    chk("stall_dst", xfer_dst, 32'hA5);
    chk("stall_src", xfer_src, 32'h77);

    // 6: asynchronous reset in the middle of a transfer with responses outstanding
    do_write(10'h000, 32'h1, 2'b00, 0);
    do_write(10'h028, 32'd100, 2'b00, 1);
    pulse(0, 1);
    do_write(10'h028, 32'd50, 2'b00, 1);
    @(posedge clk); #1;
    bus.awaddr = 10'h020; bus.wdata = 32'h22; bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
    bus.araddr = 10'h004; bus.arvalid = 1; bus.rready = 0;
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    @(negedge clk);
    chk("pre_rst_irq", irq, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_bvalid", bus.bvalid, 0);
    chk("arst_rvalid", bus.rvalid, 0);
    chk("arst_bresp", bus.bresp, 0);
    chk("arst_rresp", bus.rresp, 0);
    chk("arst_irq", irq, 0);
    chk("arst_start", xfer_start, 0);
    chk("arst_src", xfer_src, 0);
    chk("arst_len", xfer_len, 0);
    bus.bready = 1; bus.rready = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    pulse(1, 0);
    do_read(10'h004, 32'h0000_0002, 2'b00);
    chk("post_rst_irq", irq, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
